// File: rtl/universal_ff_bank.sv
// WIDTH-bit bank of universal flip-flops (D/T/JK/SR selected at run time) with sticky illegal-SR flags.
// Optional saturating toggle counter is built only when UFF_TOGGLE_CNT_EN is defined.
module universal_ff_bank #(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic             chg,
  output logic [WIDTH-1:0] sr_err,
  output logic             any_err,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] err_set;
  logic [WIDTH-1:0] flips;

  function automatic logic jk_next(input logic cur, input logic j, input logic k);
    case ({j, k})
      2'b00:   jk_next = cur;
      2'b01:   jk_next = 1'b0;
      2'b10:   jk_next = 1'b1;
      default: jk_next = ~cur;
    endcase
  endfunction

  // s=r=1 keeps the current value; the error path flags it separately
  function automatic logic sr_next(input logic cur, input logic s, input logic r);
    case ({s, r})
      2'b01:   sr_next = 1'b0;
      2'b10:   sr_next = 1'b1;
      default: sr_next = cur;
    endcase
  endfunction

  always_comb begin
    qn      = q;
    err_set = '0;
    if (en) begin
      case (mode)
        MODE_D: qn = a;
        MODE_T: qn = q ^ a;
        MODE_JK: begin
          for (int i = 0; i < WIDTH; i++) qn[i] = jk_next(q[i], a[i], b[i]);
        end
        MODE_SR: begin
          for (int i = 0; i < WIDTH; i++) qn[i] = sr_next(q[i], a[i], b[i]);
          err_set = a & b;
        end
        default: qn = q;
      endcase
    end
  end

  assign flips = q ^ qn;

  // State register stage: q, change flag and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= RESET_VAL;
      chg    <= 1'b0;
      sr_err <= '0;
    end else begin
      q      <= qn;
      chg    <= en && (|flips);
      sr_err <= (err_clr ? '0 : sr_err) | err_set;
    end
  end

  assign any_err = |sr_err;

`ifdef UFF_TOGGLE_CNT_EN
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic [PC_W-1:0] flip_cnt;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WIDTH; i++) acc = acc + PC_W'(v[i]);
    return acc;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [PC_W-1:0]  inc);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] max_v;
    sum   = SUM_W'(base) + SUM_W'(inc);
    max_v = SUM_W'({CNT_W{1'b1}});
    return (sum > max_v) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign flip_cnt = popcount(flips);

  // Counter stage: clear restarts from zero but still absorbs this cycle's flips
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_cnt <= '0;
    end else if (cnt_clr) begin
      toggle_cnt <= sat_add('0, flip_cnt);
    end else if (en) begin
      toggle_cnt <= sat_add(toggle_cnt, flip_cnt);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign toggle_cnt     = '0;
`endif

endmodule
